// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs toward the stage and the EX-side
// pipeline register outputs, plus the load-use stall back to PC/IF-ID.
interface id_ex_stage_if #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_ADD = 5,
  parameter int CTRL_W    = 8,
  parameter int CNT_W     = 16
);
  logic                 hold;
  logic                 flush;
  logic                 id_valid;
  logic [31:0]          id_instr;
  logic                 id_uses_rs;
  logic                 id_uses_rt;
  logic                 id_mem_read;
  logic                 id_reg_write;
  logic [CTRL_W-1:0]    id_ctrl;
  logic [WIDTH-1:0]     read_data1;
  logic [WIDTH-1:0]     read_data2;
  logic                 stall;
  logic                 ex_valid;
  logic [WIDTH-1:0]     ex_rs_data;
  logic [WIDTH-1:0]     ex_rt_data;
  logic [WIDTH-1:0]     ex_imm;
  logic [WIDTH_ADD-1:0] ex_rs;
  logic [WIDTH_ADD-1:0] ex_rt;
  logic [WIDTH_ADD-1:0] ex_rd;
  logic                 ex_mem_read;
  logic                 ex_reg_write;
  logic [CTRL_W-1:0]    ex_ctrl;
  logic [CNT_W-1:0]     bubble_count;

  modport master (
    output hold, flush, id_valid, id_instr, id_uses_rs, id_uses_rt,
           id_mem_read, id_reg_write, id_ctrl, read_data1, read_data2,
    input  stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
           ex_rd, ex_mem_read, ex_reg_write, ex_ctrl, bubble_count
  );

  modport slave (
    input  hold, flush, id_valid, id_instr, id_uses_rs, id_uses_rt,
           id_mem_read, id_reg_write, id_ctrl, read_data1, read_data2,
    output stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
           ex_rd, ex_mem_read, ex_reg_write, ex_ctrl, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-bubble
// insertion, branch flush, global hold and a saturating bubble counter.
module id_ex_stage #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_ADD = 5,
  parameter int CTRL_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] sign_ext16(input logic [15:0] imm);
    return WIDTH'($signed(imm));
  endfunction

  logic                 valid_r, mem_read_r, reg_write_r;
  logic [WIDTH-1:0]     rs_data_r, rt_data_r, imm_r;
  logic [WIDTH_ADD-1:0] rs_r, rt_r, rd_r;
  logic [CTRL_W-1:0]    ctrl_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 valid_s, mem_read_s, reg_write_s;
  logic [WIDTH-1:0]     rs_data_s, rt_data_s, imm_s;
  logic [WIDTH_ADD-1:0] rs_s, rt_s, rd_s;
  logic [CTRL_W-1:0]    ctrl_s;
  logic [CNT_W-1:0]     cnt_s;

  logic [WIDTH_ADD-1:0] id_rs_s, id_rt_s, id_rd_s;
  logic                 hz_s;

  assign id_rs_s = WIDTH_ADD'(bus.id_instr[25:21]);
  assign id_rt_s = WIDTH_ADD'(bus.id_instr[20:16]);
  assign id_rd_s = WIDTH_ADD'(bus.id_instr[15:11]);

  // Load-use hazard: the load in EX targets a register the ID instruction reads; $0 never counts.
  always_comb begin
    hz_s = valid_r & mem_read_r & (rt_r != {WIDTH_ADD{1'b0}}) & bus.id_valid &
           ((bus.id_uses_rs & (id_rs_s == rt_r)) | (bus.id_uses_rt & (id_rt_s == rt_r)));
  end

  assign bus.stall = hz_s & ~bus.flush & reset;

  // Next-state selection: hold > flush > hazard bubble > normal load.
  always_comb begin
    valid_s     = valid_r;
    rs_data_s   = rs_data_r;
    rt_data_s   = rt_data_r;
    imm_s       = imm_r;
    rs_s        = rs_r;
    rt_s        = rt_r;
    rd_s        = rd_r;
    mem_read_s  = mem_read_r;
    reg_write_s = reg_write_r;
    ctrl_s      = ctrl_r;
    cnt_s       = cnt_r;
    if (bus.hold) begin
      cnt_s = cnt_r;
    end else if (bus.flush || hz_s) begin
      valid_s     = 1'b0;
      rs_data_s   = {WIDTH{1'b0}};
      rt_data_s   = {WIDTH{1'b0}};
      imm_s       = {WIDTH{1'b0}};
      rs_s        = {WIDTH_ADD{1'b0}};
      rt_s        = {WIDTH_ADD{1'b0}};
      rd_s        = {WIDTH_ADD{1'b0}};
      mem_read_s  = 1'b0;
      reg_write_s = 1'b0;
      ctrl_s      = {CTRL_W{1'b0}};
      if (!bus.flush && (cnt_r != CNT_MAX)) begin
        cnt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_s = cnt_r;
      end
    end else begin
      valid_s     = bus.id_valid;
      rs_data_s   = bus.read_data1;
      rt_data_s   = bus.read_data2;
      imm_s       = sign_ext16(bus.id_instr[15:0]);
      rs_s        = id_rs_s;
      rt_s        = id_rt_s;
      rd_s        = id_rd_s;
      mem_read_s  = bus.id_mem_read & bus.id_valid;
      reg_write_s = bus.id_reg_write & bus.id_valid;
      ctrl_s      = bus.id_valid ? bus.id_ctrl : {CTRL_W{1'b0}};
    end
  end

  // Pipeline register with asynchronous clear; restarts empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r     <= 1'b0;
      rs_data_r   <= {WIDTH{1'b0}};
      rt_data_r   <= {WIDTH{1'b0}};
      imm_r       <= {WIDTH{1'b0}};
      rs_r        <= {WIDTH_ADD{1'b0}};
      rt_r        <= {WIDTH_ADD{1'b0}};
      rd_r        <= {WIDTH_ADD{1'b0}};
      mem_read_r  <= 1'b0;
      reg_write_r <= 1'b0;
      ctrl_r      <= {CTRL_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      valid_r     <= valid_s;
      rs_data_r   <= rs_data_s;
      rt_data_r   <= rt_data_s;
      imm_r       <= imm_s;
      rs_r        <= rs_s;
      rt_r        <= rt_s;
      rd_r        <= rd_s;
      mem_read_r  <= mem_read_s;
      reg_write_r <= reg_write_s;
      ctrl_r      <= ctrl_s;
      cnt_r       <= cnt_s;
    end
  end

  assign bus.ex_valid     = valid_r;
  assign bus.ex_rs_data   = rs_data_r;
  assign bus.ex_rt_data   = rt_data_r;
  assign bus.ex_imm       = imm_r;
  assign bus.ex_rs        = rs_r;
  assign bus.ex_rt        = rt_r;
  assign bus.ex_rd        = rd_r;
  assign bus.ex_mem_read  = mem_read_r;
  assign bus.ex_reg_write = reg_write_r;
  assign bus.ex_ctrl      = ctrl_r;
  assign bus.bubble_count = cnt_r;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage (4-bit bubble counter),
// plus hand sequences for reset-mid-stall and counter saturation.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.WIDTH(32), .WIDTH_ADD(5), .CTRL_W(8), .CNT_W(4)) bus ();

  id_ex_stage #(.WIDTH(32), .WIDTH_ADD(5), .CTRL_W(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        hold, flush, vld;
    logic [31:0] instr;
    logic        urs, urt, mr, rw;
    logic [7:0]  ctrl;
    logic [31:0] rd1, rd2;
    logic        x_stall, x_valid;
    logic [31:0] x_rsd, x_rtd, x_imm;
    logic [4:0]  x_rs, x_rt, x_rd;
    logic        x_mr, x_rw;
    logic [7:0]  x_ctrl;
    logic [3:0]  x_cnt;
  } vec_t;

  localparam logic [31:0] LW8  = 32'h8D28_0004;
  localparam logic [31:0] ADD  = 32'h0109_5020;
  localparam logic [31:0] ADDI = 32'h2128_FFFC;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input logic h, input logic f, input logic v, input logic [31:0] ins,
                       input logic urs, input logic urt, input logic mr, input logic rw,
                       input logic [7:0] c, input logic [31:0] d1, input logic [31:0] d2);
    bus.hold = h;  bus.flush = f;  bus.id_valid = v;  bus.id_instr = ins;
    bus.id_uses_rs = urs;  bus.id_uses_rt = urt;  bus.id_mem_read = mr;
    bus.id_reg_write = rw;  bus.id_ctrl = c;  bus.read_data1 = d1;  bus.read_data2 = d2;
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b0,1'b0,1'b1,ADDI,1'b1,1'b0,1'b0,1'b1,8'hA5,32'h5,32'h7,
                 1'b0,1'b1,32'h5,32'h7,32'hFFFF_FFFC,5'd9,5'd8,5'd31,1'b0,1'b1,8'hA5,4'd0};
    vecs[1]  = '{1'b0,1'b0,1'b1,LW8,1'b1,1'b0,1'b1,1'b1,8'h3C,32'h100,32'h55,
                 1'b0,1'b1,32'h100,32'h55,32'h4,5'd9,5'd8,5'd0,1'b1,1'b1,8'h3C,4'd0};
    vecs[2]  = '{1'b0,1'b0,1'b1,ADD,1'b1,1'b1,1'b0,1'b1,8'h11,32'hAAAA,32'hBBBB,
                 1'b1,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,1'b0,1'b0,8'h00,4'd1};
    vecs[3]  = '{1'b0,1'b0,1'b1,ADD,1'b1,1'b1,1'b0,1'b1,8'h11,32'hAAAA,32'hBBBB,
                 1'b0,1'b1,32'hAAAA,32'hBBBB,32'h5020,5'd8,5'd9,5'd10,1'b0,1'b1,8'h11,4'd1};
    vecs[4]  = '{1'b0,1'b0,1'b1,32'h8D20_0008,1'b1,1'b0,1'b1,1'b1,8'h3C,32'h100,32'h0,
                 1'b0,1'b1,32'h100,32'h0,32'h8,5'd9,5'd0,5'd0,1'b1,1'b1,8'h3C,4'd1};
    vecs[5]  = '{1'b0,1'b0,1'b1,32'h0000_5820,1'b1,1'b1,1'b0,1'b1,8'h11,32'h0,32'h0,
                 1'b0,1'b1,32'h0,32'h0,32'h5820,5'd0,5'd0,5'd11,1'b0,1'b1,8'h11,4'd1};
    vecs[6]  = '{1'b0,1'b0,1'b1,LW8,1'b1,1'b0,1'b1,1'b1,8'h3C,32'h200,32'h66,
                 1'b0,1'b1,32'h200,32'h66,32'h4,5'd9,5'd8,5'd0,1'b1,1'b1,8'h3C,4'd1};
    vecs[7]  = '{1'b0,1'b0,1'b1,32'h2128_0001,1'b1,1'b0,1'b0,1'b1,8'h22,32'h7,32'h8,
                 1'b0,1'b1,32'h7,32'h8,32'h1,5'd9,5'd8,5'd0,1'b0,1'b1,8'h22,4'd1};
    vecs[8]  = '{1'b0,1'b0,1'b1,LW8,1'b1,1'b0,1'b1,1'b1,8'h3C,32'h300,32'h77,
                 1'b0,1'b1,32'h300,32'h77,32'h4,5'd9,5'd8,5'd0,1'b1,1'b1,8'h3C,4'd1};
    vecs[9]  = '{1'b0,1'b1,1'b1,ADD,1'b1,1'b1,1'b0,1'b1,8'h11,32'hAAAA,32'hBBBB,
                 1'b0,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,1'b0,1'b0,8'h00,4'd1};
    vecs[10] = '{1'b0,1'b0,1'b1,LW8,1'b1,1'b0,1'b1,1'b1,8'h3C,32'h400,32'h88,
                 1'b0,1'b1,32'h400,32'h88,32'h4,5'd9,5'd8,5'd0,1'b1,1'b1,8'h3C,4'd1};
    vecs[11] = '{1'b1,1'b0,1'b1,ADD,1'b1,1'b1,1'b0,1'b1,8'h11,32'hAAAA,32'hBBBB,
                 1'b1,1'b1,32'h400,32'h88,32'h4,5'd9,5'd8,5'd0,1'b1,1'b1,8'h3C,4'd1};
    vecs[12] = '{1'b1,1'b0,1'b1,ADDI,1'b1,1'b0,1'b0,1'b1,8'hA5,32'h5,32'h7,
                 1'b0,1'b1,32'h400,32'h88,32'h4,5'd9,5'd8,5'd0,1'b1,1'b1,8'h3C,4'd1};
    vecs[13] = '{1'b1,1'b1,1'b1,ADD,1'b1,1'b1,1'b0,1'b1,8'h11,32'hAAAA,32'hBBBB,
                 1'b0,1'b1,32'h400,32'h88,32'h4,5'd9,5'd8,5'd0,1'b1,1'b1,8'h3C,4'd1};
    vecs[14] = '{1'b0,1'b0,1'b1,ADD,1'b1,1'b1,1'b0,1'b1,8'h11,32'hAAAA,32'hBBBB,
                 1'b1,1'b0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,1'b0,1'b0,8'h00,4'd2};
    vecs[15] = '{1'b0,1'b0,1'b1,ADD,1'b1,1'b1,1'b0,1'b1,8'h11,32'hAAAA,32'hBBBB,
                 1'b0,1'b1,32'hAAAA,32'hBBBB,32'h5020,5'd8,5'd9,5'd10,1'b0,1'b1,8'h11,4'd2};
    vecs[16] = '{1'b0,1'b0,1'b0,LW8,1'b1,1'b0,1'b1,1'b1,8'h3C,32'h123,32'h456,
                 1'b0,1'b0,32'h123,32'h456,32'h4,5'd9,5'd8,5'd0,1'b0,1'b0,8'h00,4'd2};
    vecs[17] = '{1'b0,1'b0,1'b1,ADD,1'b1,1'b1,1'b0,1'b1,8'h11,32'hAAAA,32'hBBBB,
                 1'b0,1'b1,32'hAAAA,32'hBBBB,32'h5020,5'd8,5'd9,5'd10,1'b0,1'b1,8'h11,4'd2};

    // Asynchronous reset with random inputs, before any clock edge.
    drive($urandom_range(1), $urandom_range(1), 1'b1, $urandom, 1'b1, 1'b1, 1'b1, 1'b1,
          8'($urandom), $urandom, $urandom);
    #2 reset = 1'b0;
    #1;
    chk("reset_stall", 64'(bus.stall), 64'd0);
    chk("reset_data", {bus.ex_rs_data, bus.ex_rt_data}, 64'd0);
    chk("reset_misc", 64'({bus.ex_valid, bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd,
                           bus.ex_mem_read, bus.ex_reg_write, bus.ex_ctrl, bus.bubble_count}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].hold, vecs[i].flush, vecs[i].vld, vecs[i].instr, vecs[i].urs, vecs[i].urt,
            vecs[i].mr, vecs[i].rw, vecs[i].ctrl, vecs[i].rd1, vecs[i].rd2);
      #1;
      chk($sformatf("v%0d_stall", i), 64'(bus.stall), 64'(vecs[i].x_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(bus.ex_valid), 64'(vecs[i].x_valid));
      chk($sformatf("v%0d_rsdata", i), 64'(bus.ex_rs_data), 64'(vecs[i].x_rsd));
      chk($sformatf("v%0d_rtdata", i), 64'(bus.ex_rt_data), 64'(vecs[i].x_rtd));
      chk($sformatf("v%0d_imm", i), 64'(bus.ex_imm), 64'(vecs[i].x_imm));
      chk($sformatf("v%0d_regs", i), 64'({bus.ex_rs, bus.ex_rt, bus.ex_rd}),
          64'({vecs[i].x_rs, vecs[i].x_rt, vecs[i].x_rd}));
      chk($sformatf("v%0d_flags", i), 64'({bus.ex_mem_read, bus.ex_reg_write}),
          64'({vecs[i].x_mr, vecs[i].x_rw}));
      chk($sformatf("v%0d_ctrl", i), 64'(bus.ex_ctrl), 64'(vecs[i].x_ctrl));
      chk($sformatf("v%0d_count", i), 64'(bus.bubble_count), 64'(vecs[i].x_cnt));
    end

    // Reset asserted while stalling: stall and state drop without a clock edge.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, LW8, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 32'h100, 32'h55);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, ADD, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 32'hAAAA, 32'hBBBB);
    #1;
    chk("midstall_stall_before", 64'(bus.stall), 64'd1);
    reset = 1'b0;
    #1;
    chk("midstall_stall_after", 64'(bus.stall), 64'd0);
    chk("midstall_state", 64'({bus.ex_valid, bus.ex_mem_read, bus.ex_rt, bus.bubble_count}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 17 load-use pairs saturate the 4-bit counter at 15.
    for (int p = 0; p < 17; p++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, LW8, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 32'h100, 32'h55);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, ADD, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 32'hAAAA, 32'hBBBB);
      #1;
      chk($sformatf("sat%0d_stall", p), 64'(bus.stall), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_count", p), 64'(bus.bubble_count), 64'((p + 1 > 15) ? 15 : p + 1));
    end
    chk("sat_final", 64'(bus.bubble_count), 64'd15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode (register file read) and execute in the 5-stage MIPS core.
- On each rising clk it captures the register-file read data, the decoded instruction fields, the sign-extended immediate and the control bundle for EX.
- Detects load-use hazards, drives a stall to PC/IF-ID and inserts one bubble.
- Supports branch flush, a global hold and a saturating bubble counter.

Parameters:
- WIDTH, 32, data path width; WIDTH ≥ 16.
- WIDTH_ADD, 5, register address width.
- CTRL_W, 8, width of the pass-through EX/MEM/WB control bundle.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- hold  in  1  global freeze; all state keeps its value.
- flush  in  1  taken branch/jump; the current ID instruction is discarded.
- id_valid  in  1  ID holds a real instruction.
- id_instr  in  32  fields: rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- id_uses_rs  in  1  the instruction reads rs.
- id_uses_rt  in  1  the instruction reads rt.
- id_mem_read  in  1  the instruction is a load.
- id_reg_write  in  1  the instruction writes a register.
- id_ctrl  in  CTRL_W  remaining control bits, passed through unchanged.
- read_data1  in  WIDTH  register file port 1 (rs) data.
- read_data2  in  WIDTH  register file port 2 (rt) data.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_rs_data  out  WIDTH  captured rs data.
- ex_rt_data  out  WIDTH  captured rt data.
- ex_imm  out  WIDTH  sign-extended imm.
- ex_rs, ex_rt, ex_rd  out  WIDTH_ADD each  captured register addresses.
- ex_mem_read  out  1  captured load flag.
- ex_reg_write  out  1  captured register-write flag.
- ex_ctrl  out  CTRL_W  captured control bundle.
- bubble_count  out  CNT_W  number of load-use bubbles inserted.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every registered output goes to 0 immediately, including ex_valid, all data, all address fields, ex_ctrl and bubble_count.
  - The stall output is 0 while in reset.
- Hazard term (combinational):
  - hz = ex_valid & ex_mem_read & (ex_rt≠0) & id_valid & ((id_uses_rs & rs==ex_rt) | (id_uses_rt & rt==ex_rt)).
  - stall = hz & ~flush. No register in this block gates stall.
- Rising-edge update, priority order:
  1. hold=1: every register keeps its value, including bubble_count. stall is still driven from hz.
  2. flush=1: insert a bubble (see below). bubble_count unchanged.
  3. hz=1: insert a bubble and increment bubble_count, saturating at all-ones. The ID instruction stays in IF/ID because stall=1.
  4. Otherwise, load:
     - ex_valid<=id_valid.
     - ex_rs_data<=read_data1, ex_rt_data<=read_data2.
     - ex_imm<={ {(WIDTH-16){imm[15]}}, imm }.
     - ex_rs/ex_rt/ex_rd <= the instruction fields.
     - ex_mem_read<=id_mem_read&id_valid, ex_reg_write<=id_reg_write&id_valid.
     - ex_ctrl<=id_valid ? id_ctrl : 0.
- Bubble definition: every registered output except bubble_count goes to 0, giving deterministic zeros for verification.
- Latency: ID inputs present before edge N appear on the ex_* outputs after edge N, a single cycle.
- Bubble length:
  - After one bubble, ex_mem_read=0, so stall deasserts and the held instruction loads on the next edge.
  - Exactly one bubble per load-use pair.
- Register 0 never causes a hazard, whether as a source or as the load destination.
- Register file read timing: the register file writes on the falling edge, so read_data1/2 are already correct at the rising edge. The block has no write-back bypass.
- Simultaneous events:
  - flush with hz: flush wins, stall=0, no count.
  - hold with flush or hz: hold wins and nothing changes.
- If reset asserts mid-stall, stall drops immediately. After release the pipeline restarts empty.

Test Plan:
- Reset: drive reset=0 with all inputs random → all outputs 0 immediately, asynchronously, with no clk edge. Release, then load id_instr=0x2128FFFC (addi) with read_data1=0x5 → ex_imm=0xFFFFFFFC, ex_rs=9, ex_rt=8, ex_valid=1 after one edge.
- Load-use: lw $8 in EX (ex_mem_read=1, ex_rt=8), ID add $10,$8,$9 with uses_rs=1 → stall=1. Next edge: ex_valid=0, bubble_count=1. Next cycle stall=0 and the add loads.
- No false hazard: lw $0 followed by a use of $0 → stall=0, no bubble. lw $8 followed by an instruction with id_uses_rt=0 and rt=8 → stall=0.
- Flush priority: hz and flush=1 in the same cycle → stall=0, bubble inserted, bubble_count unchanged.
- Hold: with hold=1 for 3 cycles and changing inputs → all ex_* outputs and bubble_count are stable. With a hazard present, stall is still 1.
- Saturation: with CNT_W=4, force 17 load-use pairs → bubble_count ends at 15.
